data_mem_io: RTL and testbench
==============================

Name: data_mem_io

Overview:
- Data-side memory stage directly downstream of the single-cycle ARM core.
- Consumes the core's MemWrite, ALUResult (address) and WriteData; returns ReadData in the same cycle.
- Contains a word-addressed data RAM and a memory-mapped I/O page: LED register, free-running timer with compare/IRQ, and a 4-entry UART TX FIFO drained through a valid/ready handshake to an external transmitter.

Parameters:
- RAM_AW, 6: RAM word-address width; depth = 2**RAM_AW words.
- FIFO_AW, 2: TX FIFO address width; depth = 2**FIFO_AW entries.
- MMIO_PAGE, 16'hFFFF: value of Addr[31:16] that selects the MMIO page.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  write strobe from core.
- Addr  input  32  byte address (core ALUResult).
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational from Addr.
- LED  output  8  LED register.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  transmitter accepts the head byte this cycle.
- timer_irq  output  1  timer match flag.

Behaviour:
- Decode:
  - Addr[31:16]==MMIO_PAGE selects MMIO, offset Addr[7:0].
  - All other addresses select RAM, word index Addr[RAM_AW+1:2]; upper bits are ignored, so addresses wrap modulo depth.
  - Addr[1:0] is ignored everywhere.
- RAM:
  - Read is combinational.
  - Write occurs at the CLK rise when MemWrite=1.
  - Contents are not reset.
- MMIO map (registers reset to 0):
  - 0x00 LED: RW, bits[7:0]; read returns zero-extended value.
  - 0x04 TIMER: RO count; the counter increments every cycle and wraps 0xFFFFFFFF->0. A write loads 0, so the next visible value is 0.
  - 0x08 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - 0x0C STATUS:
    - bit0 full, bit1 empty, bit2 overflow (sticky), bits[6:4] count.
    - Any write clears overflow.
  - 0x10 CMP: RW compare value.
  - 0x14 FLAG: bit0 = match flag. Writing bit0=1 clears it; writing 0 has no effect.
  - Unmapped offsets read 0; writes to them are ignored.
- Timer flag:
  - Set on the cycle after count==CMP while CMP!=0.
  - Set wins over a simultaneous W1C clear.
  - timer_irq = flag.
- TX FIFO:
  - Pop when tx_valid && tx_ready. tx_data shows the head entry; it is 0 when empty.
  - Push is accepted when not full, or when full with a simultaneous pop; in that case count stays at max and the order is preserved.
  - Push onto a full FIFO without a pop is dropped and sets overflow.
  - Pointers wrap modulo depth. The count is FIFO_AW+1 bits wide.
  - Pop when empty is impossible because tx_valid=0.
- STATUS read reflects the pre-edge state of the current cycle.
- Reset (asynchronous, mid-operation included):
  - FIFO is emptied (tx_valid=0, tx_data=0).
  - Pointers, count, overflow, LED, TIMER, CMP and FLAG are cleared to 0; timer_irq=0.
  - RAM is untouched.
  - ReadData follows decode immediately.

Optional Feature:
- Macro: DATA_MEM_TIMER_EN.
- Defined: timer, CMP, FLAG and timer_irq are implemented as above.
- Undefined: no timer logic is built. Offsets 0x04, 0x10 and 0x14 read 0 and ignore writes; timer_irq is tied to 0.

Decomposition:
- Package data_mem_pkg: MMIO offset constants (LED, TIMER, TXDATA, STATUS, CMP, FLAG) and STATUS bit-position constants.
- Sub-module tx_fifo: parameter FIFO_AW. Ports CLK, reset, push, din[7:0], pop, dout[7:0], full, empty, count, overflow, ovf_clr. It holds the pointer/count/overflow logic.
- Decode, RAM, LED and timer live in data_mem_io.

Test Plan:
- RAM: write 0x12345678 at 0x00000010, then read 0x00000010 -> 0x12345678. Read 0x00000110 (RAM_AW=6) -> the same word, confirming wrap.
- FIFO with tx_ready=0: push 0x41, 0x42, 0x43, 0x44 -> STATUS = 0x41 (full, count 4). Push 0x45 -> STATUS bit2=1 and contents unchanged. Raise tx_ready -> tx_data 0x41, 0x42, 0x43, 0x44 on successive cycles, then tx_valid=0 and STATUS=0x06.
- FIFO full, push 0x55 with tx_ready=1 in the same cycle -> 0x41 popped, 0x55 accepted, count stays 4, overflow stays 0.
- Timer (DATA_MEM_TIMER_EN defined): write CMP=10 and TIMER=0 -> timer_irq rises after the count reaches 10. Write FLAG=1 -> timer_irq=0. Write FLAG=0 -> no change.
- Timer clear at match: W1C write to FLAG in the same cycle the match is registered -> flag remains 1.
- Reset: assert reset asynchronously between edges with FIFO count 2 and LED=0xA5 -> LED=0, tx_valid=0, timer_irq=0 immediately. A RAM word written before reset reads back unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants for the data-side memory stage: MMIO offsets and STATUS layout.
// Used by data_mem_io and tx_fifo.
package data_mem_pkg;

  // MMIO register offsets within the I/O page (word aligned).
  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_TIMER  = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CMP    = 8'h10;
  localparam logic [7:0] OFF_FLAG   = 8'h14;

  // STATUS register bit positions.
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 3;

  typedef struct packed {
    logic                full;
    logic                empty;
    logic                ovf;
    logic [ST_CNT_W-1:0] cnt;
  } fifo_status_t;

  function automatic logic [31:0] status_pack(input fifo_status_t st);
    logic [31:0] word;
    word                            = '0;
    word[ST_FULL]                   = st.full;
    word[ST_EMPTY]                  = st.empty;
    word[ST_OVF]                    = st.ovf;
    word[ST_CNT_LSB +: ST_CNT_W]    = st.cnt;
    return word;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// UART transmit FIFO: byte-wide, 2**FIFO_AW deep, sticky overflow flag.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module tx_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_mem_io.sv
// Data memory stage: word RAM plus MMIO page (LED, timer/compare, UART TX FIFO).
// Optional timer block is built only when DATA_MEM_TIMER_EN is defined.
module data_mem_io
  import data_mem_pkg::*;
#(
  parameter int          RAM_AW    = 6,
  parameter int          FIFO_AW   = 2,
  parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  LED,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic              is_mmio;
  logic [7:0]        off;
  logic [RAM_AW-1:0] widx;
  logic              mmio_we;
  logic              ram_we;
  logic              unused_addr;

  assign is_mmio     = (Addr[31:16] == MMIO_PAGE);
  assign off         = {Addr[7:2], 2'b00};
  assign widx        = Addr[RAM_AW+1:2];
  assign mmio_we     = MemWrite && is_mmio;
  assign ram_we      = MemWrite && !is_mmio;
  assign unused_addr = ^{Addr[15:8], Addr[1:0]};

  // ---------------- RAM ----------------
  logic [31:0] ram [RAM_DEPTH];

  always_ff @(posedge CLK) begin
    if (ram_we) ram[widx] <= WriteData;
  end

  // ---------------- LED ----------------
  logic [7:0] led_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                           led_q <= '0;
    else if (mmio_we && off == OFF_LED)   led_q <= WriteData[7:0];
  end

  assign LED = led_q;

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_cnt;
  logic             fifo_ovf;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_ovf_clr;
  fifo_status_t     fifo_st;

  assign fifo_push    = mmio_we && (off == OFF_TXDATA);
  assign fifo_ovf_clr = mmio_we && (off == OFF_STATUS);
  assign tx_valid     = !fifo_empty;
  assign fifo_pop     = tx_valid && tx_ready;
  assign tx_data      = fifo_dout;

  tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (fifo_push),
    .din      (WriteData[7:0]),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt),
    .overflow (fifo_ovf),
    .ovf_clr  (fifo_ovf_clr)
  );

  assign fifo_st = '{full:  fifo_full,
                     empty: fifo_empty,
                     ovf:   fifo_ovf,
                     cnt:   ST_CNT_W'(fifo_cnt)};

  // ---------------- Timer / compare ----------------
  logic [31:0] timer_rd;
  logic [31:0] cmp_rd;
  logic        flag_rd;

`ifdef DATA_MEM_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        flag_q;
  logic        match;
  logic        flag_clr;

  assign match    = (timer_q == cmp_q) && (cmp_q != '0);
  assign flag_clr = mmio_we && (off == OFF_FLAG) && WriteData[0];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      cmp_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      // A write loads zero, so the count visible after the edge is 0.
      if (mmio_we && off == OFF_TIMER) timer_q <= '0;
      else                             timer_q <= timer_q + 32'd1;
      if (mmio_we && off == OFF_CMP)   cmp_q   <= WriteData;
      // A match in the same cycle as a W1C clear keeps the flag set.
      if (match)                       flag_q  <= 1'b1;
      else if (flag_clr)               flag_q  <= 1'b0;
    end
  end

  assign timer_rd  = timer_q;
  assign cmp_rd    = cmp_q;
  assign flag_rd   = flag_q;
  assign timer_irq = flag_q;
`else
  assign timer_rd  = '0;
  assign cmp_rd    = '0;
  assign flag_rd   = 1'b0;
  assign timer_irq = 1'b0;
`endif

  // ---------------- Read mux ----------------
  // NOTE: ReadData is given a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[widx];
    end else begin
      case (off)
        OFF_LED:    ReadData = {24'h0, led_q};
        OFF_TIMER:  ReadData = timer_rd;
        OFF_STATUS: ReadData = status_pack(fifo_st);
        OFF_CMP:    ReadData = cmp_rd;
        OFF_FLAG:   ReadData = {31'h0, flag_rd};
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: RAM, LED, TX FIFO scoreboard, timer, async reset.
// Timer scenarios are exercised when DATA_MEM_TIMER_EN is defined.
module tb_data_mem_io;
  import data_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  LED;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       model_ovf = 1'b0;

  data_mem_io dut (
    .CLK       (CLK),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .LED       (LED),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mmio(input logic [7:0] o);
    return {16'hFFFF, 8'h00, o};
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = sb.size();
    return (32'(n) << 4) | (32'(model_ovf) << 2) |
           ((n == 0) ? 32'h2 : 32'h0) | ((n == 4) ? 32'h1 : 32'h0);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    @(negedge CLK);
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK);
    MemWrite = 1'b0; Addr = a;
    #1 d = ReadData;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (sb.size() < 4) sb.push_back(b);
    else               model_ovf = 1'b1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    wr(mmio(OFF_TXDATA), {24'h0, b});
    model_push(b);
  endtask

  task automatic drain();
    logic [7:0] e;
    for (int i = 0; i < 16 && sb.size() > 0; i++) begin
      @(negedge CLK);
      tx_ready = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        errors++;
        $display("FAIL drain_byte: got valid=%b data=%h, want valid=1 data=%h", tx_valid, tx_data, e);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_budget: %0d bytes left, want 0", sb.size());
    end
    @(negedge CLK);
    tx_ready = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b data=%h, want valid=0 data=00", tx_valid, tx_data);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; MemWrite = 1'b0; Addr = mmio(OFF_STATUS); WriteData = '0; tx_ready = 1'b0;
    #12;
    checks++;
    if (LED !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00 || timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got led=%h valid=%b data=%h irq=%b, want 00/0/00/0", LED, tx_valid, tx_data, timer_irq);
    end
    checks++;
    if (ReadData !== 32'h2) begin
      errors++;
      $display("FAIL reset_status: got %h, want 00000002", ReadData);
    end
    @(negedge CLK);
    reset = 1'b1;
    rd(mmio(OFF_TIMER), d);
    checks++;
`ifdef DATA_MEM_TIMER_EN
    if (d === 32'h0 || d > 32'd4) begin
      errors++;
      $display("FAIL reset_timer_runs: got %h, want 1..4", d);
    end
`else
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL timer_absent: got %h, want 0", d);
    end
`endif
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h0000_0010, 32'h1234_5678);
    wr(32'h0000_0014, 32'hCAFE_F00D);
    rd(32'h0000_0010, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_read: got %h, want 12345678", d); end
    rd(32'h0000_0110, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_wrap: got %h, want 12345678", d); end
    rd(32'h0000_0013, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_byte_ofs: got %h, want 12345678", d); end
    rd(32'h8000_0014, d);
    checks++;
    if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_upper_bits: got %h, want cafef00d", d); end
  endtask

  task automatic test_led_mmio();
    logic [31:0] d;
    wr(mmio(OFF_LED), 32'h0000_01A5);
    rd(mmio(OFF_LED), d);
    checks++;
    if (d !== 32'h0000_00A5 || LED !== 8'hA5) begin
      errors++;
      $display("FAIL led_rw: got read=%h led=%h, want 000000a5/a5", d, LED);
    end
    wr(mmio(8'h40), 32'hFFFF_FFFF);
    rd(mmio(8'h40), d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, want 0", d); end
    rd(32'h0000_0010, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL mmio_no_ram_alias: got %h, want 12345678", d); end
`ifndef DATA_MEM_TIMER_EN
    wr(mmio(OFF_CMP), 32'd5);
    rd(mmio(OFF_CMP), d);
    checks++;
    if (d !== 32'h0 || timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL cmp_absent: got cmp=%h irq=%b, want 0/0", d, timer_irq);
    end
`endif
  endtask

  task automatic test_fifo_fill_drain();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) tx_push(8'h41 + 8'(i));
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL fifo_full_status: got %h, want %h", d, exp_status()); end
    tx_push(8'h45);
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL fifo_ovf_status: got %h, want %h", d, exp_status()); end
    rd(mmio(OFF_TXDATA), d);
    checks++;
    if (d !== 32'h0 || tx_data !== sb[0]) begin
      errors++;
      $display("FAIL txdata_read: got read=%h head=%h, want 0/%h", d, tx_data, sb[0]);
    end
    drain();
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL fifo_drained_status: got %h, want %h", d, exp_status()); end
    wr(mmio(OFF_STATUS), 32'h0);
    model_ovf = 1'b0;
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL ovf_clear: got %h, want %h", d, exp_status()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) tx_push(8'h41 + 8'(i));
    @(negedge CLK);
    tx_ready = 1'b1; MemWrite = 1'b1; Addr = mmio(OFF_TXDATA); WriteData = 32'h55;
    #1;
    e = sb.pop_front();
    sb.push_back(8'h55);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== e) begin
      errors++;
      $display("FAIL b2b_pop_head: got valid=%b data=%h, want 1/%h", tx_valid, tx_data, e);
    end
    @(negedge CLK);
    MemWrite = 1'b0; tx_ready = 1'b0;
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL b2b_status: got %h, want %h", d, exp_status()); end
    drain();
  endtask

`ifdef DATA_MEM_TIMER_EN
  task automatic test_timer();
    logic [31:0] d;
    logic        found;
    wr(mmio(OFF_CMP), 32'd10);
    wr(mmio(OFF_TIMER), 32'd0);
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b, want 0", timer_irq); end
    found = 1'b0;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      Addr = mmio(OFF_TIMER);
      #1;
      if (timer_irq === 1'b1) begin found = 1'b1; d = ReadData; break; end
    end
    checks++;
    if (!found || d !== 32'd11) begin
      errors++;
      $display("FAIL irq_rise: got found=%b timer=%0d, want 1/11", found, d);
    end
    wr(mmio(OFF_FLAG), 32'h0);
    rd(mmio(OFF_FLAG), d);
    checks++;
    if (d !== 32'h1 || timer_irq !== 1'b1) begin
      errors++;
      $display("FAIL flag_w0: got flag=%h irq=%b, want 1/1", d, timer_irq);
    end
    wr(mmio(OFF_FLAG), 32'h1);
    #1;
    checks++;
    if (timer_irq !== 1'b0) begin errors++; $display("FAIL flag_w1c: got %b, want 0", timer_irq); end

    // Clear issued in the very cycle the match is registered.
    wr(mmio(OFF_CMP), 32'd30);
    wr(mmio(OFF_TIMER), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      MemWrite = 1'b0; Addr = mmio(OFF_TIMER);
      #1;
      if (ReadData === 32'd30) begin
        found = 1'b1;
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL pre_match_irq: got %b, want 0", timer_irq); end
        MemWrite = 1'b1; Addr = mmio(OFF_FLAG); WriteData = 32'h1;
        break;
      end
    end
    @(negedge CLK);
    MemWrite = 1'b0;
    #1;
    checks++;
    if (!found || timer_irq !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got found=%b irq=%b, want 1/1", found, timer_irq);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] d;
    wr(32'h0000_0020, 32'hDEAD_BEEF);
    wr(mmio(OFF_LED), 32'hA5);
    tx_ready = 1'b0;
    tx_push(8'h61);
    tx_push(8'h62);
    @(negedge CLK);
    Addr = 32'h0000_0020;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (LED !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00 || timer_irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got led=%h valid=%b data=%h irq=%b, want 00/0/00/0", LED, tx_valid, tx_data, timer_irq);
    end
    checks++;
    if (ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_kept_in_reset: got %h, want deadbeef", ReadData); end
    sb.delete();
    model_ovf = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    rd(mmio(OFF_STATUS), d);
    checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL post_reset_status: got %h, want %h", d, exp_status()); end
    rd(32'h0000_0020, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_kept: got %h, want deadbeef", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_mmio();
    test_fifo_fill_drain();
    test_back_to_back();
`ifdef DATA_MEM_TIMER_EN
    test_timer();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
